acc_cpu_param: RTL and testbench

Parametrised accumulator CPU: the next generation of the team's 8-bit/16-word accumulator machine.
- Data width and address width are generalised.
- Adds reset, start/halt control, a host program-load port, a memory readback port, Z/C flags and a HLT opcode.
- Sits under a test bench or SoC host, which loads memory, starts execution, and observes AC/PC/flags/memory.

---
 rtl/acc_cpu_pkg.sv | 37 +++
 rtl/acc_cpu_mem.sv | 28 ++
 rtl/acc_cpu_param.sv | 195 +++++++++++++++++++
 tb/tb_acc_cpu_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the parametrised accumulator CPU: opcodes, FSM states
// and instruction-field positions expressed as functions of the address width.
package acc_cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_DBL = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_CMA = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_HALT
  } state_t;

  // Instruction layout: {I, opcode[2:0], address[aw-1:0]}
  function automatic int instr_w(input int aw);
    return aw + 4;
  endfunction

  function automatic int ind_bit(input int aw);
    return aw + 3;
  endfunction

  function automatic int op_lsb(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/acc_cpu_mem.sv
// Program/data memory: one write port (host or core, muxed by the caller) and
// two combinational read ports. Contents are deliberately not reset.
module acc_cpu_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: five-cycle fetch/decode/indirect/execute FSM
// with host load, readback, start/halt control and Z/C flags.
module acc_cpu_param
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [DATA_W-1:0] start_ac,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] ac,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy,
  output logic              halted
);

  localparam int IW  = instr_w(ADDR_W);
  localparam int IB  = ind_bit(ADDR_W);
  localparam int OPL = op_lsb(ADDR_W);

  generate
    if (DATA_W < ADDR_W + 4) begin : g_bad_params
      $error("acc_cpu_param: DATA_W must be at least ADDR_W+4");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] ac_reg, ac_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] ar_reg;
  logic [IW-1:0]     ir_reg;
  logic              z_reg, z_next;
  logic              c_reg, c_next;
  logic              halted_reg;

  logic [DATA_W-1:0] mem_q;
  logic              core_we;
  logic [DATA_W-1:0] core_wdata;
  logic              exec_we;
  logic              host_phase;
  logic              host_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  logic [2:0]        ir_op;
  logic              ir_ind;
  logic [ADDR_W-1:0] ir_addr;

  assign ir_op   = ir_reg[OPL+2:OPL];
  assign ir_ind  = ir_reg[IB];
  assign ir_addr = ir_reg[ADDR_W-1:0];

  assign host_phase = (state_reg == S_IDLE) || (state_reg == S_HALT);
  assign host_wr    = host_phase && load_en;
  assign exec_we    = (state_reg == S_T4) && core_we;

  // Host and core writes are mutually exclusive by state, so a simple mux suffices.
  assign mem_we    = host_wr || exec_we;
  assign mem_waddr = exec_we ? ar_reg : load_addr;
  assign mem_wdata = exec_we ? core_wdata : load_data;

  acc_cpu_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (ar_reg),
    .rdata_a (mem_q),
    .raddr_b (rd_addr),
    .rdata_b (rd_data)
  );

  // Execute-stage datapath; results are committed only in T4.
  assign sum  = {1'b0, ac_reg} + {1'b0, mem_q};
  assign diff = {1'b0, ac_reg} - {1'b0, mem_q};

  always_comb begin
    ac_next    = ac_reg;
    z_next     = z_reg;
    c_next     = c_reg;
    core_we    = 1'b0;
    core_wdata = mem_q;
    case (ir_op)
      OP_ADD: begin
        ac_next = sum[DATA_W-1:0];
        c_next  = sum[DATA_W];
        z_next  = (sum[DATA_W-1:0] == '0);
      end
      OP_SUB: begin
        ac_next = diff[DATA_W-1:0];
        c_next  = diff[DATA_W];
        z_next  = (diff[DATA_W-1:0] == '0);
      end
      OP_XOR: begin
        ac_next = ac_reg ^ mem_q;
        z_next  = ((ac_reg ^ mem_q) == '0);
      end
      OP_DBL: begin
        core_we    = 1'b1;
        core_wdata = mem_q + mem_q;
      end
      OP_LDA: begin
        ac_next = mem_q;
        z_next  = (mem_q == '0);
      end
      OP_STA: begin
        core_we    = 1'b1;
        core_wdata = ac_reg;
      end
      OP_CMA: begin
        core_we    = 1'b1;
        core_wdata = ~mem_q;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_HALT: if (start) state_next = S_T0;
      S_T0:           state_next = S_T1;
      S_T1:           state_next = S_T2;
      S_T2:           state_next = S_T3;
      S_T3:           state_next = S_T4;
      S_T4:           state_next = (ir_op == OP_HLT) ? S_HALT : S_T0;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      ac_reg     <= '0;
      pc_reg     <= '0;
      ar_reg     <= '0;
      ir_reg     <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc_reg     <= start_pc;
            ac_reg     <= start_ac;
            halted_reg <= 1'b0;
          end
        end
        S_T0: ar_reg <= pc_reg;
        S_T1: begin
          ir_reg <= mem_q[IW-1:0];
          pc_reg <= pc_reg + ADDR_W'(1);
        end
        S_T2: ar_reg <= ir_addr;
        // Single level of indirection: pointer taken from the low address bits.
        S_T3: if (ir_ind) ar_reg <= mem_q[ADDR_W-1:0];
        S_T4: begin
          ac_reg <= ac_next;
          z_reg  <= z_next;
          c_reg  <= c_next;
          if (ir_op == OP_HLT) halted_reg <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign ac     = ac_reg;
  assign pc     = pc_reg;
  assign flag_z = z_reg;
  assign flag_c = c_reg;
  assign busy   = !host_phase;
  assign halted = halted_reg;

endmodule

// File: tb/tb_acc_cpu_param.sv
// Scoreboard bench for acc_cpu_param: default 8/4 instance plus a 16/6 instance.
module tb_acc_cpu_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 0, load_en0 = 0;
  logic [3:0] start_pc0 = 0, load_addr0 = 0, rd_addr0 = 0, pc0;
  logic [7:0] start_ac0 = 0, load_data0 = 0, rd_data0, ac0;
  logic       z0, c0, busy0, halted0;

  logic        start1 = 0, load_en1 = 0;
  logic [5:0]  start_pc1 = 0, load_addr1 = 0, rd_addr1 = 0, pc1;
  logic [15:0] start_ac1 = 0, load_data1 = 0, rd_data1, ac1;
  logic        z1, c1, busy1, halted1;

  acc_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .start_pc(start_pc0), .start_ac(start_ac0),
    .load_en(load_en0), .load_addr(load_addr0), .load_data(load_data0),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .ac(ac0), .pc(pc0),
    .flag_z(z0), .flag_c(c0), .busy(busy0), .halted(halted0)
  );

  acc_cpu_param #(.DATA_W(16), .ADDR_W(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .start_pc(start_pc1), .start_ac(start_ac1),
    .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .ac(ac1), .pc(pc1),
    .flag_z(z1), .flag_c(c1), .busy(busy1), .halted(halted1)
  );

  typedef struct packed {
    logic [95:0] name;
    logic        dut;
    logic [15:0] ac;
    logic [15:0] pc;
    logic        z, c, h, b;
    logic [7:0]  cyc;   // 255 = do not check
    logic [1:0]  nmem;
    logic [5:0]  ma0, ma1;
    logic [15:0] mv0, mv1;
  } exp_t;

  exp_t q[$];
  event snap_ev;
  int checks = 0;
  int errors = 0;
  int bc0 = 0, bc1 = 0, base0 = 0, base1 = 0;

  always @(posedge clk) begin
    if (busy0) bc0 <= bc0 + 1;
    if (busy1) bc1 <= bc1 + 1;
  end

  task automatic chk(input logic [95:0] nm, input string fld, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got=%h exp=%h", nm, fld, got, exp);
    end else begin
      $display("ok   %s %s = %h", nm, fld, got);
    end
  endtask

  task automatic push(input logic [95:0] nm, input logic d, input logic [15:0] a, input logic [15:0] p,
                      input logic z, input logic c, input logic h, input logic b, input logic [7:0] cy,
                      input logic [1:0] nm_cnt, input logic [5:0] a0, input logic [15:0] v0,
                      input logic [5:0] a1, input logic [15:0] v1);
    exp_t e;
    e.name = nm; e.dut = d; e.ac = a; e.pc = p; e.z = z; e.c = c; e.h = h; e.b = b;
    e.cyc = cy; e.nmem = nm_cnt; e.ma0 = a0; e.mv0 = v0; e.ma1 = a1; e.mv1 = v1;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation whenever a DUT halts or the bench requests a snapshot.
  initial begin
    exp_t e;
    int cyc;
    forever begin
      @(posedge halted0 or posedge halted1 or snap_ev);
      @(negedge clk);
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard unexpected event got=empty_queue exp=entry");
      end else begin
        e = q.pop_front();
        if (e.dut) begin
          cyc = bc1 - base1; base1 = bc1;
          chk(e.name, "ac", ac1, e.ac);
          chk(e.name, "pc", {10'h0, pc1}, e.pc);
          chk(e.name, "z/c/h/b", {12'h0, z1, c1, halted1, busy1}, {12'h0, e.z, e.c, e.h, e.b});
        end else begin
          cyc = bc0 - base0; base0 = bc0;
          chk(e.name, "ac", {8'h0, ac0}, e.ac);
          chk(e.name, "pc", {12'h0, pc0}, e.pc);
          chk(e.name, "z/c/h/b", {12'h0, z0, c0, halted0, busy0}, {12'h0, e.z, e.c, e.h, e.b});
        end
        if (e.cyc != 8'hFF) chk(e.name, "cycles", 16'(cyc), {8'h0, e.cyc});
        if (e.nmem > 0) begin
          if (e.dut) rd_addr1 = e.ma0; else rd_addr0 = e.ma0[3:0];
          #1;
          chk(e.name, "mem0", e.dut ? rd_data1 : {8'h0, rd_data0}, e.mv0);
        end
        if (e.nmem > 1) begin
          if (e.dut) rd_addr1 = e.ma1; else rd_addr0 = e.ma1[3:0];
          #1;
          chk(e.name, "mem1", e.dut ? rd_data1 : {8'h0, rd_data0}, e.mv1);
        end
      end
    end
  end

  task automatic load0(input logic [3:0] a, input logic [7:0] d);
    load_en0 = 1; load_addr0 = a; load_data0 = d;
    @(negedge clk);
    load_en0 = 0;
  endtask

  task automatic load1(input logic [5:0] a, input logic [15:0] d);
    load_en1 = 1; load_addr1 = a; load_data1 = d;
    @(negedge clk);
    load_en1 = 0;
  endtask

  task automatic run0(input logic [3:0] p, input logic [7:0] a);
    start0 = 1; start_pc0 = p; start_ac0 = a;
    @(negedge clk);
    start0 = 0;
  endtask

  task automatic wait_halt(input logic d, input logic [95:0] nm);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (d ? halted1 : halted0) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s halt_timeout got=running exp=halted", nm);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic snap();
    -> snap_ev;
    repeat (2) @(negedge clk);
  endtask

  task automatic prog_basic();
    load0(0, 8'h48); load0(1, 8'h09); load0(2, 8'h5A); load0(3, 8'h70);
    load0(8, 8'h05); load0(9, 8'h03);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Reset state of both instances while rst_n is held low.
    push("reset0", 0, 16'h0, 16'h0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0);
    snap();
    push("reset1", 1, 16'h0, 16'h0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0);
    snap();
    rst_n = 1;
    @(negedge clk);

    // 1: LDA 8; ADD 9; STA 10; HLT
    prog_basic();
    push("t1_default", 0, 16'h08, 16'h4, 0, 0, 1, 0, 8'd20, 1, 10, 16'h08, 0, 0);
    run0(0, 8'h00);
    wait_halt(0, "t1_default");

    // 2: indirect LDA via M12 -> M13
    load0(0, 8'hCC); load0(1, 8'h70); load0(12, 8'h0D); load0(13, 8'h7F);
    push("t2_indirect", 0, 16'h7F, 16'h2, 0, 0, 1, 0, 8'd10, 0, 0, 0, 0, 0);
    run0(0, 8'h00);
    wait_halt(0, "t2_indirect");

    // 3a: SUB 8 with M8=1 from ac=0 -> borrow
    load0(0, 8'h18); load0(1, 8'h70); load0(8, 8'h01);
    push("t3_sub", 0, 16'hFF, 16'h2, 0, 1, 1, 0, 8'd10, 0, 0, 0, 0, 0);
    run0(0, 8'h00);
    wait_halt(0, "t3_sub");

    // 3b: XOR 9 with M9=FF from ac=FF -> zero, C kept
    load0(2, 8'h29); load0(3, 8'h70); load0(9, 8'hFF);
    push("t3_xor", 0, 16'h00, 16'h4, 1, 1, 1, 0, 8'd10, 0, 0, 0, 0, 0);
    run0(2, 8'hFF);
    wait_halt(0, "t3_xor");

    // 4: pc wrap 15->0, DBL 8 then CMA 8; flags untouched
    load0(15, 8'h38); load0(8, 8'h81); load0(0, 8'h68); load0(1, 8'h70);
    push("t4_wrap", 0, 16'h00, 16'h2, 1, 1, 1, 0, 8'd15, 1, 8, 16'hFD, 0, 0);
    run0(15, 8'h00);
    wait_halt(0, "t4_wrap");

    // 5a: host load and start while busy are both ignored
    prog_basic();
    load0(14, 8'h11);
    push("t5_busy", 0, 16'h08, 16'h4, 0, 0, 1, 0, 8'd20, 2, 14, 16'h11, 10, 16'h08);
    run0(0, 8'h00);
    @(negedge clk);
    load_en0 = 1; load_addr0 = 14; load_data0 = 8'hEE;
    start0 = 1; start_pc0 = 5; start_ac0 = 8'h33;
    repeat (3) @(negedge clk);
    load_en0 = 0; start0 = 0;
    wait_halt(0, "t5_busy");

    // 5b: async reset during T3 clears state, memory survives
    run0(0, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 0;
    push("t5_reset", 0, 16'h0, 16'h0, 0, 0, 0, 0, 8'hFF, 2, 8, 16'h05, 0, 16'h48);
    snap();
    rst_n = 1;
    @(negedge clk);

    // 6: 16/6 instance, ADD overflow at pc 63 then HLT at 0
    load1(63, 16'h000A); load1(10, 16'h0001); load1(0, 16'h01C0);
    push("t6_scale", 1, 16'h0000, 16'h1, 1, 1, 1, 0, 8'd10, 1, 10, 16'h0001, 0, 0);
    start1 = 1; start_pc1 = 63; start_ac1 = 16'hFFFF;
    @(negedge clk);
    start1 = 0;
    wait_halt(1, "t6_scale");

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL %s unchecked got=no_event exp=event", e.name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
